// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants
// for the bit-serial adder slice.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: 1-bit full adder, the single
// arithmetic cell reused by serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial a+b+cin
// using one full-adder cell and a carry flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW =
    (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic             load;
  logic             last;

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, status outputs and datapath strobes.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand/result shifters, carry flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      r_sr  <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (busy) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      r_sr  <= {fa_s, r_sr[WIDTH-1:1]};
      carry <= fa_c;
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  // Result registers, updated only on the completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (last) begin
      sum  <= {fa_s, r_sr[WIDTH-1:1]};
      cout <= fa_c;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench
// for serial_adder with WIDTH=8.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_chk;
  int n_fail;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Drive operands at a negedge; returns at the
  // negedge after the accepting edge.
  task automatic start_op(input logic [7:0] x,
                          input logic [7:0] y,
                          input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; counts busy samples.
  task automatic wait_done(output int bcyc,
                           output bit seen);
    bcyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bcyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b need 0 0 00 0",
               busy, done, sum, cout);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b need 0 0",
               busy, done);
    end
  endtask

  task automatic test_nominal;
    int bc;
    bit seen;
    start_op(8'h5A, 8'h33, 1'b0);
    wait_done(bc, seen);
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL nominal_timeout: done not seen");
    end
    n_chk++;
    if (bc !== 8) begin
      n_fail++;
      $display("FAIL nominal_busy_cycles: got %0d need 8", bc);
    end
    n_chk++;
    if (sum !== 8'h8D || cout !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_result: got sum=%h cout=%b busy=%b need 8d 0 0",
               sum, cout, busy);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_done_pulse: got done=%b need 0", done);
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if (sum !== 8'h8D) begin
      n_fail++;
      $display("FAIL nominal_hold: got sum=%h need 8d", sum);
    end
  endtask

  task automatic test_carry;
    int bc;
    bit seen;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(bc, seen);
    n_chk++;
    if (!seen || sum !== 8'h00 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_ripple: got seen=%b sum=%h cout=%b need 1 00 1",
               seen, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_all_ones;
    int bc;
    bit seen;
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(bc, seen);
    n_chk++;
    if (!seen || sum !== 8'hFF || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL all_ones_cin: got seen=%b sum=%h cout=%b need 1 ff 1",
               seen, sum, cout);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int bc;
    bit seen;
    int extra;
    start_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hAA;
    b     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (sum !== 8'hFF || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold_prev: got sum=%h cout=%b need ff 1",
               sum, cout);
    end
    wait_done(bc, seen);
    n_chk++;
    if (!seen || sum !== 8'h30 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy: got seen=%b sum=%h cout=%b need 1 30 0",
               seen, sum, cout);
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    n_chk++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL no_second_op: got %0d active cycles need 0", extra);
    end
  endtask

  task automatic test_reset_mid;
    int bc;
    bit seen;
    int pulses;
    start_op(8'h5A, 8'h33, 1'b0);
    wait_done(bc, seen);
    n_chk++;
    if (!seen || sum !== 8'h8D) begin
      n_fail++;
      $display("FAIL rst_mid_prior: got seen=%b sum=%h need 1 8d",
               seen, sum);
    end
    @(negedge clk);
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, sum, cout} !== 11'd0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got busy=%b done=%b sum=%h cout=%b need 0 0 00 0",
               busy, done, sum, cout);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_chk++;
    if (pulses !== 0 || sum !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_discard: got active=%0d sum=%h need 0 00",
               pulses, sum);
    end
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(bc, seen);
    n_chk++;
    if (!seen || sum !== 8'h02 || cout !== 1'b0 || bc !== 8) begin
      n_fail++;
      $display("FAIL rst_mid_after: got seen=%b sum=%h cout=%b busy=%0d need 1 02 0 8",
               seen, sum, cout, bc);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int  bc;
    bit  seen;
    time t1;
    time t2;
    start_op(8'h11, 8'h22, 1'b0);
    wait_done(bc, seen);
    t1 = $time;
    n_chk++;
    if (!seen || sum !== 8'h33 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got seen=%b sum=%h cout=%b need 1 33 0",
               seen, sum, cout);
    end
    a     = 8'h80;
    b     = 8'h80;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b need 1 0",
               busy, done);
    end
    wait_done(bc, seen);
    t2 = $time;
    n_chk++;
    if (!seen || (t2 - t1) !== 90) begin
      n_fail++;
      $display("FAIL b2b_spacing: got seen=%b gap=%0t need 1 90",
               seen, t2 - t1);
    end
    n_chk++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_result: got sum=%h cout=%b need 00 1",
               sum, cout);
    end
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_nominal();
    test_carry();
    test_all_ones();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
